// File: rtl/perf_counter_bank_pkg.sv
// Shared types and defaults for the performance counter bank and its channels.
package PerfCounterTypes;

    localparam int DEF_NUM_CHANNELS  = 8;
    localparam int DEF_COUNTER_WIDTH = 32;
    localparam int DEF_LANES         = 2;
    localparam int DEF_SATURATE      = 1;
    // Widest counter the read-path struct can carry.
    localparam int PCT_MAX_WIDTH     = 64;
    localparam int PCT_IDX_W         = $clog2(DEF_NUM_CHANNELS) + 1;

    typedef enum logic {
        PCM_WRAP     = 1'b0,
        PCM_SATURATE = 1'b1
    } PerfCounterMode;

    typedef logic [PCT_IDX_W-1:0] PerfChannelIndex;

    typedef struct packed {
        logic                     valid;
        logic                     err;
        logic [PCT_MAX_WIDTH-1:0] data;
    } PerfCounterReadPath;

endpackage

// File: rtl/perf_counter_channel.sv
// One event counter: per-cycle lane popcount, (W+1)-bit add, clamp or wrap, sticky overflow.
module perf_counter_channel
    import PerfCounterTypes::*;
#(
    parameter int             COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int             LANES         = DEF_LANES,
    parameter PerfCounterMode MODE          = PCM_SATURATE
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic                     clear,
    input  logic [LANES-1:0]         events,
    output logic [COUNTER_WIDTH-1:0] count,
    output logic                     overflow
);

    localparam int INC_W = $clog2(LANES + 1);

    logic [INC_W-1:0]         inc;
    logic [COUNTER_WIDTH:0]   sum;
    logic                     carry;

    always_comb begin
        inc = '0;
        if (enable) begin
            for (int l = 0; l < LANES; l++) begin
                inc = inc + INC_W'(events[l]);
            end
        end
    end

    // The extra top bit is the carry-out: it flags both saturation and wrap.
    assign sum   = {1'b0, count} + {{(COUNTER_WIDTH + 1 - INC_W){1'b0}}, inc};
    assign carry = sum[COUNTER_WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (carry) begin
            overflow <= 1'b1;
            count    <= (MODE == PCM_SATURATE) ? '1 : sum[COUNTER_WIDTH-1:0];
        end else begin
            count    <= sum[COUNTER_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with a shadow snapshot and a registered 1-cycle read port.
module perf_counter_bank
    import PerfCounterTypes::*;
#(
    parameter int NUM_CHANNELS  = DEF_NUM_CHANNELS,
    parameter int COUNTER_WIDTH = DEF_COUNTER_WIDTH,
    parameter int LANES         = DEF_LANES,
    parameter int SATURATE      = DEF_SATURATE
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enable,
    input  logic [NUM_CHANNELS*LANES-1:0]     eventIn,
    input  logic                              clear,
    input  logic                              snapReq,
    input  logic                              rdReq,
    input  logic [$clog2(NUM_CHANNELS):0]     rdIndex,
    output logic                              rdValid,
    output logic [COUNTER_WIDTH-1:0]          rdData,
    output logic                              rdErr,
    output logic [NUM_CHANNELS-1:0]           overflow
);

    localparam int             IDX_W = $clog2(NUM_CHANNELS) + 1;
    localparam int             SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam PerfCounterMode MODE  = (SATURATE != 0) ? PCM_SATURATE : PCM_WRAP;
    localparam logic [IDX_W-1:0] NUM_CH_IDX = IDX_W'(NUM_CHANNELS);

    logic [COUNTER_WIDTH-1:0] count  [NUM_CHANNELS];
    logic [COUNTER_WIDTH-1:0] shadow [NUM_CHANNELS];
    PerfCounterReadPath       read_q;
    logic [SEL_W-1:0]         sel;
    logic                     in_range;

    for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
        perf_counter_channel #(
            .COUNTER_WIDTH (COUNTER_WIDTH),
            .LANES         (LANES),
            .MODE          (MODE)
        ) u_ch (
            .clk      (clk),
            .rst      (rst),
            .enable   (enable),
            .clear    (clear),
            .events   (eventIn[c*LANES +: LANES]),
            .count    (count[c]),
            .overflow (overflow[c])
        );
    end

    // Snapshot takes the counters as registered at cycle start, so a same-cycle clear is not seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CHANNELS; c++) shadow[c] <= '0;
        end else if (snapReq) begin
            for (int c = 0; c < NUM_CHANNELS; c++) shadow[c] <= count[c];
        end
    end

    // Read port: no ready/backpressure. rdReq is sampled every cycle and answered with a one-cycle
    // rdValid pulse next cycle; rdData/rdErr hold their last response while rdValid is low.
    assign sel      = rdIndex[SEL_W-1:0];
    assign in_range = (rdIndex < NUM_CH_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            read_q <= '0;
        end else if (rdReq) begin
            read_q.valid <= 1'b1;
            read_q.err   <= ~in_range;
            read_q.data  <= in_range ? PCT_MAX_WIDTH'(shadow[sel]) : '0;
        end else begin
            read_q.valid <= 1'b0;
        end
    end

    if (COUNTER_WIDTH < PCT_MAX_WIDTH) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^read_q.data[PCT_MAX_WIDTH-1:COUNTER_WIDTH];
    end

    assign rdValid = read_q.valid;
    assign rdErr   = read_q.err;
    assign rdData  = read_q.data[COUNTER_WIDTH-1:0];

endmodule

// File: tb/tb_perf_counter_bank.sv
// Bench for perf_counter_bank: three instances (32-bit saturating, 4-bit saturating, 4-bit wrapping)
// share one stimulus stream and are checked against an arithmetic reference model.
module tb_perf_counter_bank;

    localparam int NC = 8;
    localparam int NL = 2;

    logic          clk;
    logic          rst;
    logic          enable;
    logic [15:0]   event_in;
    logic          clear;
    logic          snap_req;
    logic          rd_req;
    logic [3:0]    rd_index;

    logic          rd_valid_0, rd_valid_1, rd_valid_2;
    logic [31:0]   rd_data_0;
    logic [3:0]    rd_data_1, rd_data_2;
    logic          rd_err_0, rd_err_1, rd_err_2;
    logic [7:0]    overflow_0, overflow_1, overflow_2;

    perf_counter_bank #(.NUM_CHANNELS(NC), .COUNTER_WIDTH(32), .LANES(NL), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .enable(enable), .eventIn(event_in), .clear(clear),
        .snapReq(snap_req), .rdReq(rd_req), .rdIndex(rd_index),
        .rdValid(rd_valid_0), .rdData(rd_data_0), .rdErr(rd_err_0), .overflow(overflow_0)
    );

    perf_counter_bank #(.NUM_CHANNELS(NC), .COUNTER_WIDTH(4), .LANES(NL), .SATURATE(1)) u_sat4 (
        .clk(clk), .rst(rst), .enable(enable), .eventIn(event_in), .clear(clear),
        .snapReq(snap_req), .rdReq(rd_req), .rdIndex(rd_index),
        .rdValid(rd_valid_1), .rdData(rd_data_1), .rdErr(rd_err_1), .overflow(overflow_1)
    );

    perf_counter_bank #(.NUM_CHANNELS(NC), .COUNTER_WIDTH(4), .LANES(NL), .SATURATE(0)) u_wrap4 (
        .clk(clk), .rst(rst), .enable(enable), .eventIn(event_in), .clear(clear),
        .snapReq(snap_req), .rdReq(rd_req), .rdIndex(rd_index),
        .rdValid(rd_valid_2), .rdData(rd_data_2), .rdErr(rd_err_2), .overflow(overflow_2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard counters
    int n_checks = 0;
    int n_fail   = 0;

    // reference model, one row per instance
    int     inst_w   [3] = '{32, 4, 4};
    bit     inst_sat [3] = '{1'b1, 1'b1, 1'b0};
    longint m_cnt    [3][NC];
    longint m_shadow [3][NC];
    bit     m_ov     [3][NC];
    bit     m_valid  [3];
    bit     m_err    [3];
    longint m_data   [3];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 1'b0;
            m_err[k]   = 1'b0;
            m_data[k]  = 0;
            for (int c = 0; c < NC; c++) begin
                m_cnt[k][c]    = 0;
                m_shadow[k][c] = 0;
                m_ov[k][c]     = 1'b0;
            end
        end
    endfunction

    // One clock edge of behaviour, evaluated from the inputs present at that edge.
    function automatic void model_step();
        longint limit, sum;
        int inc;
        for (int k = 0; k < 3; k++) begin
            limit = longint'(1) << inst_w[k];
            if (rd_req) begin
                m_valid[k] = 1'b1;
                if (int'(rd_index) >= NC) begin
                    m_err[k]  = 1'b1;
                    m_data[k] = 0;
                end else begin
                    m_err[k]  = 1'b0;
                    m_data[k] = m_shadow[k][rd_index];
                end
            end else begin
                m_valid[k] = 1'b0;
            end
            if (snap_req) begin
                for (int c = 0; c < NC; c++) m_shadow[k][c] = m_cnt[k][c];
            end
            for (int c = 0; c < NC; c++) begin
                if (clear) begin
                    m_cnt[k][c] = 0;
                    m_ov[k][c]  = 1'b0;
                end else begin
                    inc = enable ? $countones(event_in[c*NL +: NL]) : 0;
                    sum = m_cnt[k][c] + inc;
                    if (sum >= limit) begin
                        m_ov[k][c]  = 1'b1;
                        m_cnt[k][c] = inst_sat[k] ? (limit - 1) : (sum - limit);
                    end else begin
                        m_cnt[k][c] = sum;
                    end
                end
            end
        end
    endfunction

    function automatic logic [7:0] exp_ov(input int k);
        logic [7:0] v;
        for (int c = 0; c < NC; c++) v[c] = m_ov[k][c];
        return v;
    endfunction

    task automatic compare_all();
        check_eq("i0_valid", 64'(rd_valid_0), 64'(m_valid[0]));
        check_eq("i0_data",  64'(rd_data_0),  64'(m_data[0]));
        check_eq("i0_err",   64'(rd_err_0),   64'(m_err[0]));
        check_eq("i0_ovf",   64'(overflow_0), 64'(exp_ov(0)));
        check_eq("i1_valid", 64'(rd_valid_1), 64'(m_valid[1]));
        check_eq("i1_data",  64'(rd_data_1),  64'(m_data[1]));
        check_eq("i1_err",   64'(rd_err_1),   64'(m_err[1]));
        check_eq("i1_ovf",   64'(overflow_1), 64'(exp_ov(1)));
        check_eq("i2_valid", 64'(rd_valid_2), 64'(m_valid[2]));
        check_eq("i2_data",  64'(rd_data_2),  64'(m_data[2]));
        check_eq("i2_err",   64'(rd_err_2),   64'(m_err[2]));
        check_eq("i2_ovf",   64'(overflow_2), 64'(exp_ov(2)));
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_valid"}, 64'({rd_valid_0, rd_valid_1, rd_valid_2}), 64'd0);
        check_eq({tag, "_data0"}, 64'(rd_data_0), 64'd0);
        check_eq({tag, "_data12"}, 64'({rd_data_1, rd_data_2}), 64'd0);
        check_eq({tag, "_err"}, 64'({rd_err_0, rd_err_1, rd_err_2}), 64'd0);
        check_eq({tag, "_ovf"}, 64'({overflow_0, overflow_1, overflow_2}), 64'd0);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        compare_all();
    endtask

    task automatic run_events(input int n, input logic [15:0] ev);
        event_in = ev;
        repeat (n) tick();
        event_in = '0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic snap_read(input logic [3:0] idx);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        rd_req   = 1'b1;
        rd_index = idx;
        tick();
        rd_req   = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b1;
        event_in = '0;
        clear    = 1'b0;
        snap_req = 1'b0;
        rd_req   = 1'b0;
        rd_index = '0;
        model_reset();
        #1;
        check_all_zero("por");
        tick();
        tick();
        rst = 1'b0;

        // Reset mid-count: ch0 reaches 5, ch7 overflows the 4-bit banks.
        run_events(5, 16'hC001);
        run_events(3, 16'hC000);
        snap_read(4'd0);
        check_eq("pre_rst_data", 64'(rd_data_0), 64'd5);
        check_eq("pre_rst_ovf7", 64'(overflow_1[7]), 64'd1);
        #3;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        model_reset();
        #1;
        rst = 1'b0;
        run_events(1, 16'h0001);
        snap_read(4'd0);
        check_eq("post_rst_cnt", 64'(rd_data_0), 64'd1);

        // Multi-lane: ch3 both lanes for 4 cycles.
        do_clear();
        run_events(4, 16'h00C0);
        snap_read(4'd3);
        check_eq("multilane_valid", 64'(rd_valid_0), 64'd1);
        check_eq("multilane_data", 64'(rd_data_0), 64'd8);

        // Saturate from 14 with two events, then hold at 15.
        do_clear();
        run_events(7, 16'h0003);
        run_events(1, 16'h0003);
        check_eq("sat_ovf", 64'(overflow_1[0]), 64'd1);
        run_events(3, 16'h0003);
        snap_read(4'd0);
        check_eq("sat_hold", 64'(rd_data_1), 64'd15);

        // Wrap from 15 with one event, then count on.
        do_clear();
        run_events(15, 16'h0004);
        run_events(1, 16'h0004);
        check_eq("wrap_ovf", 64'(overflow_2[1]), 64'd1);
        run_events(1, 16'h0004);
        snap_read(4'd1);
        check_eq("wrap_data", 64'(rd_data_2), 64'd1);
        check_eq("wrap_ovf_sticky", 64'(overflow_2[1]), 64'd1);

        // clear + snap + event + read in one cycle.
        do_clear();
        run_events(3, 16'h0010);
        snap_req = 1'b1;
        tick();
        snap_req = 1'b0;
        run_events(4, 16'h0010);
        clear    = 1'b1;
        snap_req = 1'b1;
        rd_req   = 1'b1;
        rd_index = 4'd2;
        event_in = 16'h0030;
        tick();
        clear    = 1'b0;
        snap_req = 1'b0;
        event_in = '0;
        check_eq("csr_old_shadow", 64'(rd_data_0), 64'd3);
        check_eq("csr_ovf", 64'({overflow_0, overflow_1, overflow_2}), 64'd0);
        tick();
        check_eq("csr_new_shadow", 64'(rd_data_0), 64'd7);
        rd_index = 4'd8;
        tick();
        check_eq("oob_valid", 64'(rd_valid_0), 64'd1);
        check_eq("oob_err", 64'(rd_err_0), 64'd1);
        check_eq("oob_data", 64'(rd_data_0), 64'd0);
        rd_req = 1'b0;
        tick();
        check_eq("oob_hold_err", 64'(rd_err_0), 64'd1);
        snap_read(4'd2);
        check_eq("csr_cleared", 64'(rd_data_0), 64'd0);

        // enable=0 with events present.
        do_clear();
        run_events(2, 16'h0300);
        enable = 1'b0;
        run_events(5, 16'hFFFF);
        enable = 1'b1;
        snap_read(4'd4);
        check_eq("disabled_hold", 64'(rd_data_0), 64'd4);

        // Randomised traffic.
        for (int i = 0; i < 3000; i++) begin
            enable   = ($urandom_range(0, 9) != 0);
            event_in = 16'($urandom);
            clear    = ($urandom_range(0, 39) == 0);
            snap_req = ($urandom_range(0, 7) == 0);
            rd_req   = ($urandom_range(0, 1) == 0);
            rd_index = 4'($urandom_range(0, 15));
            tick();
        end
        clear    = 1'b0;
        snap_req = 1'b0;
        rd_req   = 1'b0;
        event_in = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
